// File: rtl/line_rotation_pkg.sv
// Shared constants, types and cut-position mapping for line rotation.
// Used by both the scrambler and descrambler sides.
package line_rotation_pkg;

  localparam int RAW_CUT_W = 8;
  localparam int CUT_W     = 11;
  localparam int ADDR_W    = CUT_W + 1;

  typedef logic [CUT_W-1:0] line_idx_t;

  localparam line_idx_t CUT_MIN = line_idx_t'(16);
  localparam line_idx_t CUT_MAX = line_idx_t'(1416);

  // cut = 16 + 4*floor(raw*11/8)
  function automatic line_idx_t interpolate_cut_position(
    input logic [RAW_CUT_W-1:0] raw
  );
    logic [11:0] prod;
    prod = 12'(raw) * 12'd11;
    return CUT_MIN + {prod[11:3], 2'b00};
  endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Simple dual-port line RAM, one write and one registered read port.
// Ports: clk, we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o.
module line_buffer_dp
  import line_rotation_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_rotation_descrambler.sv
// Rotates each scrambled line back by its cut using a ping-pong buffer.
// Ports: in_* sample stream + raw cut key, out_* restored stream, line_error.
// Optional DESCRAMBLE_BYPASS_EN adds a per-line bypass input.
module line_rotation_descrambler
  import line_rotation_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int LINE_LEN = 1440
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sol,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [RAW_CUT_W-1:0] raw_cut_position,
`ifdef DESCRAMBLE_BYPASS_EN
  input  logic                 bypass,
`endif
  output logic                 out_valid,
  output logic                 out_sol,
  output logic                 out_eol,
  output logic [DATA_W-1:0]    out_data,
  output logic                 line_error
);

  localparam line_idx_t LEN  = line_idx_t'(LINE_LEN);
  localparam line_idx_t LAST = line_idx_t'(LINE_LEN - 1);

  logic byp_in;
`ifdef DESCRAMBLE_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  line_idx_t wr_idx_q, wr_idx_d;
  line_idx_t wr_cut_q, wr_cut_d;
  line_idx_t rd_cut_q, rd_cut_d;
  logic      wr_bank_q, wr_bank_d;
  logic      in_line_q, in_line_d;
  logic      prev_ok_q, prev_ok_d;
  logic      wr_byp_q, wr_byp_d;
  logic      rd_byp_q, rd_byp_d;
  logic      err_q, err_d;
  logic      ov_q, ov_d;
  logic      os_q, os_d;
  logic      oe_q, oe_d;

  logic              sol_beat;
  logic              mid_beat;
  logic              line_done;
  logic              rd_ok;
  logic              rd_en;
  logic              wr_en;
  logic              rd_byp;
  line_idx_t         j;
  line_idx_t         cut;
  line_idx_t         rd_idx;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;

  assign sol_beat  = in_valid & in_sol;
  assign mid_beat  = in_valid & ~in_sol & in_line_q
                   & (wr_idx_q < LEN);
  assign line_done = in_line_q & (wr_idx_q == LEN);

  // On the sol beat the swap has not landed yet, so the
  // just-completed line's state is taken straight from the
  // write-side registers.
  always_comb begin
    j      = sol_beat ? '0 : wr_idx_q;
    rd_ok  = sol_beat ? line_done : prev_ok_q;
    rd_byp = sol_beat ? wr_byp_q : rd_byp_q;
    cut    = sol_beat ? wr_cut_q : rd_cut_q;
    if (rd_byp) cut = '0;
  end

  // Wrap without exceeding 11 bits: j-cut or j+(LEN-cut).
  assign rd_idx = (j >= cut) ? (j - cut)
                             : (j + (LEN - cut));

  assign wr_en = sol_beat | mid_beat;
  assign rd_en = (sol_beat | mid_beat) & rd_ok;

  // Write and read banks are always opposite.
  assign waddr = sol_beat ? {~wr_bank_q, line_idx_t'(0)}
                          : {wr_bank_q, wr_idx_q};
  assign raddr = sol_beat ? {wr_bank_q, rd_idx}
                          : {~wr_bank_q, rd_idx};

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    in_line_d = in_line_q;
    wr_cut_d  = wr_cut_q;
    rd_cut_d  = rd_cut_q;
    prev_ok_d = prev_ok_q;
    wr_byp_d  = wr_byp_q;
    rd_byp_d  = rd_byp_q;
    if (sol_beat) begin
      wr_idx_d  = line_idx_t'(1);
      wr_bank_d = ~wr_bank_q;
      in_line_d = 1'b1;
      wr_cut_d  = interpolate_cut_position(raw_cut_position);
      rd_cut_d  = wr_cut_q;
      prev_ok_d = line_done;
      wr_byp_d  = byp_in;
      rd_byp_d  = wr_byp_q;
    end else if (mid_beat) begin
      wr_idx_d  = wr_idx_q + line_idx_t'(1);
    end
    err_d = sol_beat & in_line_q & (wr_idx_q != LEN);
    ov_d  = rd_en;
    os_d  = rd_en & sol_beat;
    oe_d  = rd_en & ~sol_beat & (wr_idx_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      in_line_q <= 1'b0;
      wr_cut_q  <= '0;
      rd_cut_q  <= '0;
      prev_ok_q <= 1'b0;
      wr_byp_q  <= 1'b0;
      rd_byp_q  <= 1'b0;
      err_q     <= 1'b0;
      ov_q      <= 1'b0;
      os_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      in_line_q <= in_line_d;
      wr_cut_q  <= wr_cut_d;
      rd_cut_q  <= rd_cut_d;
      prev_ok_q <= prev_ok_d;
      wr_byp_q  <= wr_byp_d;
      rd_byp_q  <= rd_byp_d;
      err_q     <= err_d;
      ov_q      <= ov_d;
      os_q      <= os_d;
      oe_q      <= oe_d;
    end
  end

  line_buffer_dp #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (waddr),
    .wdata_i (in_data),
    .re_i    (rd_en),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // RAM output has no reset; gate it so idle data reads 0.
  assign out_valid  = ov_q;
  assign out_sol    = os_q;
  assign out_eol    = oe_q;
  assign out_data   = ov_q ? rdata : '0;
  assign line_error = err_q;

endmodule

// File: tb/tb_line_rotation_descrambler.sv
// Directed bench for line_rotation_descrambler.
// Line data is scr[k] = k + off, off distinct per line.
module tb_line_rotation_descrambler;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_sol;
  logic [DW-1:0] in_data;
  logic [7:0]    raw_cut_position;
`ifdef DESCRAMBLE_BYPASS_EN
  logic          bypass;
`endif
  logic          out_valid;
  logic          out_sol;
  logic          out_eol;
  logic [DW-1:0] out_data;
  logic          line_error;

  int errors = 0;
  int checks = 0;

  int cnt_valid, lat_bad, n_sol, sol_at;
  int n_eol, eol_at, err_cnt, err_at0;
  int cap [0:2047];

  always #5 clk = ~clk;

  line_rotation_descrambler #(
    .DATA_W   (DW),
    .LINE_LEN (1440)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_sol           (in_sol),
    .in_data          (in_data),
    .raw_cut_position (raw_cut_position),
`ifdef DESCRAMBLE_BYPASS_EN
    .bypass           (bypass),
`endif
    .out_valid        (out_valid),
    .out_sol          (out_sol),
    .out_eol          (out_eol),
    .out_data         (out_data),
    .line_error       (line_error)
  );

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic sample(input bit drv, input int j);
    if (out_valid) begin
      cnt_valid++;
      if (!drv) lat_bad++;
      else cap[j] = int'(out_data);
      if (out_sol) begin n_sol++; sol_at = j; end
      if (out_eol) begin n_eol++; eol_at = j; end
    end
    if (line_error) begin
      err_cnt++;
      if (drv && j == 0) err_at0 = 1;
    end
  endtask

  task automatic run_line(input int raw, input int n,
                          input int gap, input int off,
                          input bit sol_en, input bit byp);
    cnt_valid = 0; lat_bad = 0;
    n_sol = 0; sol_at = -1; n_eol = 0; eol_at = -1;
    err_cnt = 0; err_at0 = 0;
    for (int i = 0; i < 2048; i++) cap[i] = -1;
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1;
      in_sol = sol_en && (j == 0);
      in_data = DW'(j + off);
      raw_cut_position = 8'(raw);
`ifdef DESCRAMBLE_BYPASS_EN
      bypass = byp;
`endif
      @(posedge clk); #1;
      sample(1'b1, j);
      in_valid = 1'b0;
      in_sol = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        sample(1'b0, j);
      end
    end
    if (byp) ;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_sol = 1'b0;
    in_data = '0;
    raw_cut_position = '0;
`ifdef DESCRAMBLE_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_err", int'(line_error), 0);
    chk("rst_sol", int'(out_sol), 0);
    chk("rst_eol", int'(out_eol), 0);
    reset = 1'b0;

    // A: raw 0 (cut 16), first line after reset
    run_line(0, 1440, 0, 0, 1'b1, 1'b0);
    chk("A_no_out", cnt_valid, 0);

    // B: emits A rotated back by 16
    run_line(255, 1440, 0, 100, 1'b1, 1'b0);
    chk("B_cnt", cnt_valid, 1440);
    chk("B_d0", cap[0], 1424);
    chk("B_nsol", n_sol, 1);
    chk("B_solat", sol_at, 0);
    chk("B_d16", cap[16], 0);
    chk("B_d1439", cap[1439], 1423);
    chk("B_neol", n_eol, 1);
    chk("B_eolat", eol_at, 1439);
    chk("B_lat", lat_bad, 0);
    chk("B_err", err_cnt, 0);

    // C: emits B (cut 1416, off 100); gapped input
    run_line(69, 1440, 2, 200, 1'b1, 1'b0);
    chk("C_cnt", cnt_valid, 1440);
    chk("C_d0", cap[0], 124);
    chk("C_d1415", cap[1415], 1539);
    chk("C_d1416", cap[1416], 100);
    chk("C_lat", lat_bad, 0);

    // D: emits C (cut 392, off 200); gapped input
    run_line(3, 1440, 2, 300, 1'b1, 1'b0);
    chk("D_cnt", cnt_valid, 1440);
    chk("D_d0", cap[0], 1248);
    chk("D_d392", cap[392], 200);
    chk("D_d1439", cap[1439], 1247);
    chk("D_lat", lat_bad, 0);
    chk("D_eolat", eol_at, 1439);

    // E: emits D (cut 32, off 300) until reset at 700
    run_line(0, 700, 0, 400, 1'b1, 1'b0);
    chk("E_cnt", cnt_valid, 700);
    chk("E_d0", cap[0], 1708);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("E_rst_valid", int'(out_valid), 0);
    chk("E_rst_data", int'(out_data), 0);
    reset = 1'b0;
    run_line(0, 740, 0, 400, 1'b0, 1'b0);
    chk("E_tail", cnt_valid, 0);

    // F: first full line after reset emits nothing
    run_line(0, 1440, 0, 500, 1'b1, 1'b0);
    chk("F_cnt", cnt_valid, 0);
    chk("F_err", err_cnt, 0);

    // G: short line; emits first 1000 of F
    run_line(0, 1000, 0, 600, 1'b1, 1'b0);
    chk("G_cnt", cnt_valid, 1000);
    chk("G_d0", cap[0], 1924);

    // H: error for short G, no output; 60 extra
    run_line(0, 1500, 0, 700, 1'b1, 1'b0);
    chk("H_err_at", err_at0, 1);
    chk("H_err_cnt", err_cnt, 1);
    chk("H_cnt", cnt_valid, 0);

    // I: emits H (cut 16, off 700), extras ignored
    run_line(0, 1500, 0, 800, 1'b1, 1'b0);
    chk("I_cnt", cnt_valid, 1440);
    chk("I_d0", cap[0], 2124);
    chk("I_d16", cap[16], 700);
    chk("I_d1439", cap[1439], 2123);
    chk("I_eolat", eol_at, 1439);
    chk("I_err", err_cnt, 0);

`ifdef DESCRAMBLE_BYPASS_EN
    // J bypassed with raw 69; K emits J unrotated
    run_line(69, 1440, 0, 900, 1'b1, 1'b1);
    chk("J_cnt", cnt_valid, 1440);
    run_line(0, 1440, 0, 1000, 1'b1, 1'b0);
    chk("K_cnt", cnt_valid, 1440);
    chk("K_d0", cap[0], 900);
    chk("K_d500", cap[500], 1400);
    chk("K_d1439", cap[1439], 2339);
    chk("K_solat", sol_at, 0);
    chk("K_eolat", eol_at, 1439);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
